// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the risc_v_mike load/store unit.
package risc_v_mike_pkg;

  // Datapath width of the core and of the data memory words
  localparam int DATA_32_W = 32;

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Control states of the load/store unit
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_RESP  = 2'd1,
    STORE_RESP = 2'd2,
    RMW_WRITE  = 2'd3
  } lsu_state_e;

  // True when the access size is a halfword (LH, LHU or SH)
  function automatic logic is_half_access(input logic [2:0] funct3);
    return (funct3[1:0] == 2'b01);
  endfunction

  // True when the access size is a full word (LW or SW)
  function automatic logic is_word_access(input logic [2:0] funct3);
    return (funct3 == F3_LW);
  endfunction

endpackage

// File: rtl/risc_v_mike_lsu_align.sv
// Combinational lane handling: extracts and extends load lanes and merges
// sub-word store data into the word read back from memory.
module risc_v_mike_lsu_align
  import risc_v_mike_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [1:0]           byte_off,
  input  logic [DATA_32_W-1:0] rd_word,
  input  logic [DATA_32_W-1:0] wr_data,
  output logic [DATA_32_W-1:0] load_data,
  output logic [DATA_32_W-1:0] merged_word
);

  logic [4:0]           shift;
  logic [DATA_32_W-1:0] shifted;
  logic [DATA_32_W-1:0] lane_mask;
  logic [DATA_32_W-1:0] lane_data;

  assign shift   = {byte_off, 3'b000};
  assign shifted = rd_word >> shift;

  // Pick the addressed lane out of the read word and extend it to 32 bits
  always_comb begin
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  load_data = {24'h000000, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  load_data = {16'h0000, shifted[15:0]};
      F3_LW:   load_data = shifted;
      default: load_data = '0;
    endcase
  end

  // Overlay the new byte/halfword onto the old word at the addressed lane
  always_comb begin
    lane_mask   = '0;
    lane_data   = '0;
    merged_word = wr_data;
    case (funct3)
      F3_SB: begin
        lane_mask   = 32'h0000_00FF << shift;
        lane_data   = (wr_data & 32'h0000_00FF) << shift;
        merged_word = (rd_word & ~lane_mask) | lane_data;
      end
      F3_SH: begin
        lane_mask   = 32'h0000_FFFF << shift;
        lane_data   = (wr_data & 32'h0000_FFFF) << shift;
        merged_word = (rd_word & ~lane_mask) | lane_data;
      end
      default: merged_word = wr_data;
    endcase
  end

endmodule

// File: rtl/risc_v_mike_load_store_unit.sv
// Load/store unit between the core and a word-addressed data memory.
// Word stores go straight out; byte/halfword stores use a read-modify-write.
module risc_v_mike_load_store_unit
  import risc_v_mike_pkg::*;
#(
  parameter int DATA_MEM_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lsu_req_valid,
  input  logic                 lsu_req_we,
  input  logic [2:0]           lsu_req_funct3,
  input  logic [DATA_32_W-1:0] lsu_req_addr,
  input  logic [DATA_32_W-1:0] lsu_req_wr_data,
  output logic                 lsu_req_ready,
  output logic                 lsu_resp_valid,
  output logic [DATA_32_W-1:0] lsu_resp_rd_data,
  output logic                 lsu_resp_misaligned,
  output logic                 lsu_resp_addr_err,
  output logic [DATA_32_W-1:0] data_mem_addr,
  output logic                 data_mem_write,
  output logic [DATA_32_W-1:0] data_mem_wr_data,
  input  logic [DATA_32_W-1:0] data_mem_rd_data
);

  localparam logic [DATA_32_W-1:0] DEPTH_W = DATA_32_W'(DATA_MEM_DEPTH);

  lsu_state_e           state_q;
  lsu_state_e           state_d;
  logic [DATA_32_W-1:0] rmw_word_q;
  logic [DATA_32_W-1:0] rmw_index_q;
  logic [DATA_32_W-1:0] rd_data_q;
  logic                 misaligned_q;
  logic                 addr_err_q;

  logic [DATA_32_W-1:0] word_index;
  logic                 unsupported;
  logic                 req_misaligned;
  logic                 req_addr_err;
  logic                 req_fault;
  logic                 accept;
  logic [DATA_32_W-1:0] load_ext;
  logic [DATA_32_W-1:0] merged_word;

  assign word_index = {2'b00, lsu_req_addr[DATA_32_W-1:2]};
  assign accept     = lsu_req_valid & lsu_req_ready;

  risc_v_mike_lsu_align u_align (
    .funct3      (lsu_req_funct3),
    .byte_off    (lsu_req_addr[1:0]),
    .rd_word     (data_mem_rd_data),
    .wr_data     (lsu_req_wr_data),
    .load_data   (load_ext),
    .merged_word (merged_word)
  );

  // Classify the incoming request: unsupported size, misalignment, range
  always_comb begin
    unsupported = 1'b0;
    if (lsu_req_we) begin
      unsupported = (lsu_req_funct3 > F3_SW);
    end else begin
      unsupported = !(lsu_req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    end
    req_misaligned = unsupported
                   | (is_half_access(lsu_req_funct3) & lsu_req_addr[0])
                   | (is_word_access(lsu_req_funct3) & (|lsu_req_addr[1:0]));
    req_addr_err   = (word_index >= DEPTH_W);
    req_fault      = req_misaligned | req_addr_err;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and memory/handshake outputs; reset overrides everything
  always_comb begin
    state_d          = state_q;
    lsu_req_ready    = 1'b0;
    lsu_resp_valid   = 1'b0;
    data_mem_write   = 1'b0;
    data_mem_addr    = word_index;
    data_mem_wr_data = lsu_req_wr_data;
    case (state_q)
      IDLE: begin
        lsu_req_ready = 1'b1;
        if (lsu_req_valid) begin
          if (req_fault) begin
            state_d = STORE_RESP;
          end else if (!lsu_req_we) begin
            state_d = LOAD_RESP;
          end else if (lsu_req_funct3 == F3_SW) begin
            data_mem_write = 1'b1;
            state_d        = STORE_RESP;
          end else begin
            state_d = RMW_WRITE;
          end
        end
      end
      RMW_WRITE: begin
        data_mem_write   = 1'b1;
        data_mem_addr    = rmw_index_q;
        data_mem_wr_data = rmw_word_q;
        state_d          = STORE_RESP;
      end
      LOAD_RESP, STORE_RESP: begin
        lsu_resp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d        = IDLE;
      lsu_req_ready  = 1'b0;
      lsu_resp_valid = 1'b0;
      data_mem_write = 1'b0;
    end
  end

  // Capture response data, fault flags and the read-modify-write word on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q    <= '0;
      misaligned_q <= 1'b0;
      addr_err_q   <= 1'b0;
      rmw_word_q   <= '0;
      rmw_index_q  <= '0;
    end else if (accept) begin
      misaligned_q <= req_misaligned;
      addr_err_q   <= req_addr_err;
      rd_data_q    <= (!req_fault && !lsu_req_we) ? load_ext : '0;
      if (!req_fault && lsu_req_we && (lsu_req_funct3 != F3_SW)) begin
        rmw_word_q  <= merged_word;
        rmw_index_q <= word_index;
      end
    end
  end

  assign lsu_resp_rd_data    = rd_data_q;
  assign lsu_resp_misaligned = misaligned_q;
  assign lsu_resp_addr_err   = addr_err_q;

endmodule

// File: tb/tb_risc_v_mike_load_store_unit.sv
// Directed self-checking bench for the load/store unit with a 16-word memory model.
module tb_risc_v_mike_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req_valid;
  logic        lsu_req_we;
  logic [2:0]  lsu_req_funct3;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_wr_data;
  logic        lsu_req_ready;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_rd_data;
  logic        lsu_resp_misaligned;
  logic        lsu_resp_addr_err;
  logic [31:0] data_mem_addr;
  logic        data_mem_write;
  logic [31:0] data_mem_wr_data;
  logic [31:0] data_mem_rd_data;

  logic [31:0] mem [0:15];
  logic        mem_clear;
  int          write_count = 0;
  int          accept_count = 0;
  int          errors = 0;
  int          checks = 0;

  logic        acc_ready;
  logic        acc_write;
  logic [31:0] acc_wdata;
  logic [31:0] acc_maddr;

  risc_v_mike_load_store_unit #(.DATA_MEM_DEPTH(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .lsu_req_valid       (lsu_req_valid),
    .lsu_req_we          (lsu_req_we),
    .lsu_req_funct3      (lsu_req_funct3),
    .lsu_req_addr        (lsu_req_addr),
    .lsu_req_wr_data     (lsu_req_wr_data),
    .lsu_req_ready       (lsu_req_ready),
    .lsu_resp_valid      (lsu_resp_valid),
    .lsu_resp_rd_data    (lsu_resp_rd_data),
    .lsu_resp_misaligned (lsu_resp_misaligned),
    .lsu_resp_addr_err   (lsu_resp_addr_err),
    .data_mem_addr       (data_mem_addr),
    .data_mem_write      (data_mem_write),
    .data_mem_wr_data    (data_mem_wr_data),
    .data_mem_rd_data    (data_mem_rd_data)
  );

  always #5 clk = ~clk;

  // Asynchronous-read data memory model
  assign data_mem_rd_data = (data_mem_addr < 32'd16) ? mem[data_mem_addr[3:0]] : 32'h0;

  // Memory write port plus write counter
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (data_mem_write) begin
      if (data_mem_addr < 32'd16) mem[data_mem_addr[3:0]] <= data_mem_wr_data;
      write_count <= write_count + 1;
    end
  end

  // Count handshakes
  always @(posedge clk) begin
    if (lsu_req_valid && lsu_req_ready) accept_count <= accept_count + 1;
  end

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  // Present one request for one cycle; records acceptance-cycle signals, returns at edge+1
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    lsu_req_valid   = 1'b1;
    lsu_req_we      = we;
    lsu_req_funct3  = f3;
    lsu_req_addr    = addr;
    lsu_req_wr_data = wd;
    #1;
    acc_ready = lsu_req_ready;
    acc_write = data_mem_write;
    acc_wdata = data_mem_wr_data;
    acc_maddr = data_mem_addr;
    @(posedge clk);
    #1;
    lsu_req_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_clear = 1'b1;
    lsu_req_valid = 1'b0;
    lsu_req_we = 1'b0;
    lsu_req_funct3 = 3'b000;
    lsu_req_addr = 32'h0;
    lsu_req_wr_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp_valid: got %b expected 0", lsu_resp_valid); end
    checks++; if (data_mem_write !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_write: got %b expected 0", data_mem_write); end
    checks++; if (lsu_resp_rd_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_rd_data: got %h expected 0", lsu_resp_rd_data); end
    checks++; if ({lsu_resp_misaligned, lsu_resp_addr_err} !== 2'b00) begin errors++; $display("[TB] FAIL rst_err_flags: got %b expected 00", {lsu_resp_misaligned, lsu_resp_addr_err}); end
    @(negedge clk);
    rst = 1'b0;
    mem_clear = 1'b0;
    #1;
    checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready: got %b expected 1", lsu_req_ready); end
  endtask

  task automatic test_sw_lw();
    int wc0;
    wc0 = write_count;
    issue(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
    checks++; if (acc_ready !== 1'b1) begin errors++; $display("[TB] FAIL sw_ready: got %b expected 1", acc_ready); end
    checks++; if (acc_write !== 1'b1) begin errors++; $display("[TB] FAIL sw_write_strobe: got %b expected 1", acc_write); end
    checks++; if (acc_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sw_wdata: got %h expected deadbeef", acc_wdata); end
    checks++; if (acc_maddr !== 32'h2) begin errors++; $display("[TB] FAIL sw_word_index: got %h expected 2", acc_maddr); end
    checks++; if (lsu_resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL sw_resp_valid: got %b expected 1", lsu_resp_valid); end
    checks++; if (lsu_resp_rd_data !== 32'h0) begin errors++; $display("[TB] FAIL sw_resp_data: got %h expected 0", lsu_resp_rd_data); end
    checks++; if (mem[2] !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sw_mem2: got %h expected deadbeef", mem[2]); end
    step();
    checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL sw_resp_pulse: got %b expected 0", lsu_resp_valid); end
    issue(1'b0, 3'b010, 32'h8, 32'h0);
    checks++; if (lsu_resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL lw_resp_valid: got %b expected 1", lsu_resp_valid); end
    checks++; if (lsu_resp_rd_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL lw_data: got %h expected deadbeef", lsu_resp_rd_data); end
    step();
    checks++; if (write_count !== wc0 + 1) begin errors++; $display("[TB] FAIL sw_lw_write_count: got %0d expected %0d", write_count, wc0 + 1); end
  endtask

  task automatic test_sb_rmw();
    issue(1'b1, 3'b000, 32'hB, 32'h12345680);
    checks++; if (acc_write !== 1'b0) begin errors++; $display("[TB] FAIL sb_first_cycle_write: got %b expected 0", acc_write); end
    checks++; if (data_mem_write !== 1'b1) begin errors++; $display("[TB] FAIL sb_rmw_write: got %b expected 1", data_mem_write); end
    checks++; if (data_mem_addr !== 32'h2) begin errors++; $display("[TB] FAIL sb_rmw_addr: got %h expected 2", data_mem_addr); end
    checks++; if (data_mem_wr_data !== 32'h80ADBEEF) begin errors++; $display("[TB] FAIL sb_rmw_data: got %h expected 80adbeef", data_mem_wr_data); end
    checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL sb_early_resp: got %b expected 0", lsu_resp_valid); end
    step();
    checks++; if (lsu_resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL sb_resp_valid: got %b expected 1", lsu_resp_valid); end
    checks++; if (mem[2] !== 32'h80ADBEEF) begin errors++; $display("[TB] FAIL sb_mem2: got %h expected 80adbeef", mem[2]); end
    step();
    issue(1'b0, 3'b000, 32'hB, 32'h0);
    checks++; if (lsu_resp_rd_data !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL lb_sign_ext: got %h expected ffffff80", lsu_resp_rd_data); end
    step();
    issue(1'b0, 3'b100, 32'hB, 32'h0);
    checks++; if (lsu_resp_rd_data !== 32'h00000080) begin errors++; $display("[TB] FAIL lbu_zero_ext: got %h expected 00000080", lsu_resp_rd_data); end
    step();
  endtask

  task automatic test_sh_rmw();
    issue(1'b1, 3'b001, 32'h6, 32'h00001234);
    checks++; if (data_mem_wr_data !== 32'h12340000) begin errors++; $display("[TB] FAIL sh_rmw_data: got %h expected 12340000", data_mem_wr_data); end
    step();
    checks++; if (mem[1] !== 32'h12340000) begin errors++; $display("[TB] FAIL sh_mem1: got %h expected 12340000", mem[1]); end
    step();
    issue(1'b0, 3'b001, 32'h6, 32'h0);
    checks++; if (lsu_resp_rd_data !== 32'h00001234) begin errors++; $display("[TB] FAIL lh_data: got %h expected 00001234", lsu_resp_rd_data); end
    step();
  endtask

  task automatic test_faults();
    int wc0;
    wc0 = write_count;
    issue(1'b0, 3'b010, 32'h5, 32'h0);
    checks++; if ({lsu_resp_valid, lsu_resp_misaligned, lsu_resp_addr_err} !== 3'b110) begin errors++; $display("[TB] FAIL lw_misaligned: got %b expected 110", {lsu_resp_valid, lsu_resp_misaligned, lsu_resp_addr_err}); end
    step();
    issue(1'b1, 3'b001, 32'h3, 32'hFFFF);
    checks++; if (acc_write !== 1'b0) begin errors++; $display("[TB] FAIL sh_misaligned_write: got %b expected 0", acc_write); end
    checks++; if ({lsu_resp_valid, lsu_resp_misaligned, lsu_resp_addr_err} !== 3'b110) begin errors++; $display("[TB] FAIL sh_misaligned: got %b expected 110", {lsu_resp_valid, lsu_resp_misaligned, lsu_resp_addr_err}); end
    step();
    checks++; if (data_mem_write !== 1'b0) begin errors++; $display("[TB] FAIL sh_misaligned_no_rmw: got %b expected 0", data_mem_write); end
    issue(1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    checks++; if (acc_write !== 1'b0) begin errors++; $display("[TB] FAIL sw_range_write: got %b expected 0", acc_write); end
    checks++; if ({lsu_resp_valid, lsu_resp_misaligned, lsu_resp_addr_err} !== 3'b101) begin errors++; $display("[TB] FAIL sw_addr_err: got %b expected 101", {lsu_resp_valid, lsu_resp_misaligned, lsu_resp_addr_err}); end
    step();
    issue(1'b0, 3'b011, 32'h0, 32'h0);
    checks++; if ({lsu_resp_valid, lsu_resp_misaligned, lsu_resp_rd_data} !== {2'b11, 32'h0}) begin errors++; $display("[TB] FAIL ld_unsupported: got %b_%h expected 11_00000000", {lsu_resp_valid, lsu_resp_misaligned}, lsu_resp_rd_data); end
    step();
    checks++; if (write_count !== wc0) begin errors++; $display("[TB] FAIL fault_write_count: got %0d expected %0d", write_count, wc0); end
  endtask

  task automatic test_reset_mid_rmw();
    int wc0;
    wc0 = write_count;
    issue(1'b1, 3'b000, 32'h8, 32'h11);
    checks++; if (data_mem_write !== 1'b1) begin errors++; $display("[TB] FAIL rmw_before_rst: got %b expected 1", data_mem_write); end
    rst = 1'b1;
    #1;
    checks++; if (data_mem_write !== 1'b0) begin errors++; $display("[TB] FAIL rst_blocks_write: got %b expected 0", data_mem_write); end
    step();
    checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_resp: got %b expected 0", lsu_resp_valid); end
    checks++; if (mem[2] !== 32'h80ADBEEF) begin errors++; $display("[TB] FAIL rst_mid_mem2: got %h expected 80adbeef", mem[2]); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (lsu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_ready: got %b expected 1", lsu_req_ready); end
    step();
    checks++; if ({lsu_resp_valid, data_mem_write} !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_late: got %b expected 00", {lsu_resp_valid, data_mem_write}); end
    checks++; if (write_count !== wc0) begin errors++; $display("[TB] FAIL rst_mid_write_count: got %0d expected %0d", write_count, wc0); end
  endtask

  task automatic test_back_to_back();
    int ac0;
    ac0 = accept_count;
    @(negedge clk);
    lsu_req_valid  = 1'b1;
    lsu_req_we     = 1'b0;
    lsu_req_funct3 = 3'b010;
    lsu_req_addr   = 32'h8;
    step();
    checks++; if ({lsu_req_ready, lsu_resp_valid} !== 2'b01) begin errors++; $display("[TB] FAIL b2b_ready_in_resp: got %b expected 01", {lsu_req_ready, lsu_resp_valid}); end
    checks++; if (lsu_resp_rd_data !== 32'h80ADBEEF) begin errors++; $display("[TB] FAIL b2b_first_data: got %h expected 80adbeef", lsu_resp_rd_data); end
    lsu_req_addr = 32'h4;
    step();
    checks++; if ({lsu_req_ready, lsu_resp_valid} !== 2'b10) begin errors++; $display("[TB] FAIL b2b_idle: got %b expected 10", {lsu_req_ready, lsu_resp_valid}); end
    checks++; if (accept_count !== ac0 + 1) begin errors++; $display("[TB] FAIL b2b_one_accept: got %0d expected %0d", accept_count, ac0 + 1); end
    step();
    lsu_req_valid = 1'b0;
    checks++; if (lsu_resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_valid: got %b expected 1", lsu_resp_valid); end
    checks++; if (lsu_resp_rd_data !== 32'h12340000) begin errors++; $display("[TB] FAIL b2b_second_data: got %h expected 12340000", lsu_resp_rd_data); end
    checks++; if (accept_count !== ac0 + 2) begin errors++; $display("[TB] FAIL b2b_two_accepts: got %0d expected %0d", accept_count, ac0 + 2); end
    step();
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_sw_lw();
    test_sb_rmw();
    test_sh_rmw();
    test_faults();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/risc_v_mike_load_store_unit.md
RISC_V_MIKE_LOAD_STORE_UNIT -- requirements
Module: risc_v_mike_load_store_unit

Interface
REQ-001 SHALL have parameter DATA_MEM_DEPTH, default 16, giving the number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have core-side inputs:
- lsu_req_valid, 1, request present.
- lsu_req_we, 1, store=1 / load=0.
- lsu_req_funct3, 3, RV32I access size and sign.
- lsu_req_addr, DATA_32_W, byte address.
- lsu_req_wr_data, DATA_32_W, store data in bits [7:0]/[15:0]/[31:0].
REQ-005 SHALL have core-side outputs:
- lsu_req_ready, 1, request accepted this cycle.
- lsu_resp_valid, 1, one-cycle completion pulse.
- lsu_resp_rd_data, DATA_32_W, extended load result.
- lsu_resp_misaligned, 1, alignment fault.
- lsu_resp_addr_err, 1, word index out of range.
REQ-006 SHALL have memory-side outputs:
- data_mem_addr, DATA_32_W, word index = byte address >> 2.
- data_mem_write, 1, write strobe.
- data_mem_wr_data, DATA_32_W, full word to write.
REQ-007 SHALL have memory-side input data_mem_rd_data, DATA_32_W, same-cycle read of the addressed word.

Function
REQ-008 SHALL accept a request when lsu_req_valid & lsu_req_ready; lsu_req_ready SHALL be 1 only in state IDLE.
REQ-009 SHALL implement FSM states IDLE, LOAD_RESP, STORE_RESP, RMW_WRITE.
REQ-010 SHALL treat a request as misaligned for:
- LH/LHU/SH with addr[0]=1.
- LW/SW with addr[1:0]!=0.
REQ-011 SHALL treat a request as an address error when addr[31:2] >= DATA_MEM_DEPTH.
REQ-012 SHALL handle faults and unsupported funct3 (loads 011/110/111, stores >=011) as follows: no data_mem_write, next state STORE_RESP, and the corresponding error bit set with the response; unsupported funct3 sets lsu_resp_misaligned.
REQ-013 SHALL, for an accepted load, register the selected and extended lane and go to LOAD_RESP; the load result SHALL be valid with lsu_resp_valid exactly 1 cycle after acceptance.
REQ-014 SHALL zero-extend for LBU/LHU and sign-extend from bit 7/15 for LB/LH.
REQ-015 SHALL, for an accepted SW, assert data_mem_write in the acceptance cycle with wr_data unchanged, then go to STORE_RESP.
REQ-016 SHALL, for an accepted SB/SH, capture in the acceptance cycle the merge of data_mem_rd_data with the new byte/halfword at lane addr[1:0], plus the word index, and go to RMW_WRITE.
REQ-017 SHALL, in RMW_WRITE, drive the captured word and index with data_mem_write=1, then go to STORE_RESP.
REQ-018 SHALL assert lsu_resp_valid for exactly one cycle in LOAD_RESP and STORE_RESP, then return to IDLE.
REQ-019 SHALL hold lsu_resp_rd_data at 0 for store responses and keep it stable until the next response.
REQ-020 SHALL ignore lsu_req_valid outside IDLE; requests SHALL NOT be queued.
REQ-021 SHALL drive data_mem_write=0 in every cycle not covered by REQ-015 or REQ-017.

Reset
REQ-022 SHALL, while rst=1, force state IDLE, clear all response outputs and captured registers to 0, and force data_mem_write=0 combinationally.
REQ-023 SHALL drop a request in progress when reset is asserted mid-operation, including RMW_WRITE: no write and no response is issued.
REQ-024 SHALL drive lsu_req_ready=1 in the first cycle after rst deasserts.

Structure
REQ-025 SHALL define the FSM state enum lsu_state_e and the funct3 constants (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101) in risc_v_mike_pkg.
REQ-026 SHALL place lane extraction, extension, and store merge in a combinational sub-module risc_v_mike_lsu_align; all registers SHALL remain in the top module.

Verification
REQ-027 SHALL cover SW at addr 0x8 with 0xDEADBEEF, then LW at 0x8 -> one write to word 2; load response 1 cycle after acceptance = 0xDEADBEEF.
REQ-028 SHALL cover SB of 0x80 at 0xB over 0xDEADBEEF, then LB and LBU at 0xB -> RMW writes word 2 = 0x80ADBEEF in the second cycle; LB=0xFFFFFF80, LBU=0x00000080.
REQ-029 SHALL cover SH of 0x1234 at 0x6 over 0x0, then LH at 0x6 -> word 1 = 0x12340000; LH=0x00001234.
REQ-030 SHALL cover LW at 0x5, SH at 0x3, and SW at 0x40 with depth 16 -> no data_mem_write; misaligned/misaligned/addr_err responses respectively.
REQ-031 SHALL cover rst asserted during RMW_WRITE of an SB -> memory unchanged, no lsu_resp_valid, lsu_req_ready=1 after release.
REQ-032 SHALL cover back-to-back valid held high for two loads -> second accepted only after the first response; ready low in LOAD_RESP.
